// File: rtl/start_screen_painter_if.sv
// Bus between the start-screen painter, the game FSM, the image ROM and the
// VGA adapter.
// FSM handshake: the FSM holds draw high to request a frame; the painter
// answers with a single-cycle done pulse once every pixel has been plotted,
// and will not start another frame until draw has been seen low.
// ROM: rom_data is valid exactly one cycle after rom_addr is presented.
// VGA: x/y/colour are meaningful only in cycles where plot is high.
interface start_screen_painter_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int ADDR_W   = 15,
    parameter int COLOUR_W = 3
);
    logic                draw;
    logic [COLOUR_W-1:0] rom_data;
    logic [ADDR_W-1:0]   rom_addr;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                done;

    // Painter side
    modport master (
        input  draw, rom_data,
        output rom_addr, x, y, colour, plot, done
    );

    // FSM / ROM / VGA side
    modport slave (
        output draw, rom_data,
        input  rom_addr, x, y, colour, plot, done
    );
endinterface

// File: rtl/start_screen_painter.sv
// Start-screen painter: sweeps the whole frame in raster order on a draw
// request, reading each pixel colour from the image ROM and plotting it,
// then pulses done for one cycle.
// Optional feature macro: DRAW_ABORT_EN -- when defined, draw dropping during
// SWEEP or FLUSH abandons the frame (back to IDLE, no done pulse).
module start_screen_painter #(
    parameter int WIDTH    = 160,
    parameter int HEIGHT   = 120,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int ADDR_W   = 15,
    parameter int COLOUR_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    start_screen_painter_if.master  bus,
    output logic [2:0]              o_state
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SWEEP = 3'd1,
        S_FLUSH = 3'd2,
        S_DONE  = 3'd3,
        S_REARM = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [X_W-1:0]      r_x_out;
    logic [Y_W-1:0]      r_y_out;
    logic                r_plot;
    logic                r_done;
    logic                w_abort;

`ifdef DRAW_ABORT_EN
    assign w_abort = ~bus.draw;
`else
    assign w_abort = 1'b0;
`endif

    // Sequencer: address/x/y counters advance together so that the address
    // always equals y*WIDTH+x without a multiplier; outputs are delayed one
    // stage to line up with the ROM read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_x_out <= '0;
            r_y_out <= '0;
            r_plot  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_x_out <= r_x;
            r_y_out <= r_y;
            r_plot  <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_addr <= '0;
                    r_x    <= '0;
                    r_y    <= '0;
                    if (bus.draw) r_state <= S_SWEEP;
                end
                S_SWEEP: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_addr  <= '0;
                        r_x     <= '0;
                        r_y     <= '0;
                    end else begin
                        // Address presented this cycle is plotted next cycle.
                        r_plot <= 1'b1;
                        if (r_addr == LAST_ADDR) begin
                            r_state <= S_FLUSH;
                            r_addr  <= '0;
                            r_x     <= '0;
                            r_y     <= '0;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                            if (r_x == LAST_X) begin
                                r_x <= '0;
                                r_y <= r_y + Y_W'(1);
                            end else begin
                                r_x <= r_x + X_W'(1);
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_REARM;
                end
                S_REARM: begin
                    // Hold off until the FSM has released its request.
                    if (!bus.draw) r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rom_addr = r_addr;
    assign bus.x        = r_x_out;
    assign bus.y        = r_y_out;
    assign bus.plot     = r_plot;
    assign bus.done     = r_done;
    // ROM data is only meaningful while plotting; gating also makes colour
    // read 0 as soon as reset clears the plot register.
    assign bus.colour   = r_plot ? bus.rom_data : '0;
    assign o_state      = r_state;
endmodule

// File: tb/tb_start_screen_painter.sv
// Bench for start_screen_painter: small 4x3 frame with a scoreboard, plus a
// default-size 160x120 instance for the full-frame checks.
module tb_start_screen_painter;
    localparam int SW = 4;
    localparam int SH = 3;
    localparam int SN = SW * SH;
    localparam int BN = 160 * 120;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Cycle counter: advances on each active edge.
    always @(posedge clk) cyc <= cyc + 1;

    start_screen_painter_if #(.X_W(8), .Y_W(7), .ADDR_W(15), .COLOUR_W(3)) s_if ();
    start_screen_painter_if #(.X_W(8), .Y_W(7), .ADDR_W(15), .COLOUR_W(3)) b_if ();
    logic [2:0] s_state;
    logic [2:0] b_state;

    start_screen_painter #(.WIDTH(SW), .HEIGHT(SH), .X_W(8), .Y_W(7), .ADDR_W(15), .COLOUR_W(3))
        u_small (.clk(clk), .reset(reset), .bus(s_if.master), .o_state(s_state));

    start_screen_painter u_big (.clk(clk), .reset(reset), .bus(b_if.master), .o_state(b_state));

    // ROM models: colour = address[2:0], one cycle latency.
    always @(posedge clk) s_if.rom_data <= s_if.rom_addr[2:0];
    always @(posedge clk) b_if.rom_data <= b_if.rom_addr[2:0];

    logic [63:0] exp_q[$];
    int          done_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input int c, input int px, input int py, input int col);
        return {32'(c), 8'(px), 8'(py), 8'(col), 8'h00};
    endfunction

    // Scoreboard monitor for the small instance.
    always @(negedge clk) begin
        if (!reset) begin
            if (s_if.plot) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_plot", {63'h0, s_if.plot}, 64'h0);
                end else begin
                    check("plot", pack(cyc, int'(s_if.x), int'(s_if.y), int'(s_if.colour)),
                          exp_q.pop_front());
                end
            end
            if (s_if.done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", {63'h0, s_if.done}, 64'h0);
                end else begin
                    check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                end
            end
        end
    end

    // Statistics monitor for the default-size instance.
    int b_plots = 0, b_last_x = 0, b_last_y = 0, b_first_cyc = -1, b_prev_cyc = -1;
    int b_gaps = 0, b_bad_col = 0, b_done_cnt = 0, b_done_cyc = -1;
    always @(negedge clk) begin
        if (!reset) begin
            if (b_if.plot) begin
                if (b_first_cyc < 0) b_first_cyc = cyc;
                else if (b_prev_cyc != cyc - 1) b_gaps++;
                b_prev_cyc = cyc;
                b_plots++;
                b_last_x = int'(b_if.x);
                b_last_y = int'(b_if.y);
                if (int'(b_if.colour) != (int'(b_if.y) * 160 + int'(b_if.x)) % 8) b_bad_col++;
            end
            if (b_if.done) begin
                b_done_cnt++;
                b_done_cyc = cyc;
            end
        end
    end

    // After the edge that samples draw=1 (edge 0): push the expected frame.
    // Spec cycle k corresponds to cyc == c0 + k - 1.
    task automatic push_sweep(input int npix, input bit with_done);
        int c0;
        @(posedge clk);
        #1;
        c0 = cyc;
        for (int i = 0; i < npix; i++)
            exp_q.push_back(pack(c0 + i + 1, i % SW, i / SW, i % 8));
        if (with_done) done_q.push_back(c0 + SN + 1);
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check(name, 64'(exp_q.size() + done_q.size()), 64'h0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rom_addr"}, 64'(s_if.rom_addr), 64'h0);
        check({tag, "_x"},        64'(s_if.x),        64'h0);
        check({tag, "_y"},        64'(s_if.y),        64'h0);
        check({tag, "_colour"},   64'(s_if.colour),   64'h0);
        check({tag, "_plot"},     64'(s_if.plot),     64'h0);
        check({tag, "_done"},     64'(s_if.done),     64'h0);
    endtask

    // Watchdog: stop with a FAIL line if anything hangs.
    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        reset = 1'b1;
        s_if.draw = 1'b0;
        b_if.draw = 1'b0;
        #1;
        check_zero_outputs("reset");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full small sweep with colour passthrough.
        s_if.draw = 1'b1;
        push_sweep(SN, 1'b1);
        wait_drain("sweep1_drain", SN + 10);

        // Held request: no re-sweep while draw stays high.
        repeat (50) @(negedge clk);
        check("held_state_rearm", 64'(s_state), 64'd4);
        s_if.draw = 1'b0;
        @(negedge clk);
        s_if.draw = 1'b1;
        push_sweep(SN, 1'b1);
        wait_drain("sweep2_drain", SN + 10);
        s_if.draw = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_release", 64'(s_state), 64'd0);

        // Reset mid-sweep when y=1.
        s_if.draw = 1'b1;
        push_sweep(SN, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(s_if.plot && s_if.y == 7'd1) && n < SN + 10);
        check("reached_y1", 64'(s_if.y), 64'd1);
        #2;
        exp_q.delete();
        done_q.delete();
        reset = 1'b1;
        #1;
        check_zero_outputs("midreset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_sweep(SN, 1'b1);
        wait_drain("restart_drain", SN + 10);
        s_if.draw = 1'b0;
        repeat (3) @(negedge clk);

        // Drop draw while pixel 5 is plotted (cycle 7).
        s_if.draw = 1'b1;
`ifdef DRAW_ABORT_EN
        push_sweep(6, 1'b0);
`else
        push_sweep(SN, 1'b1);
`endif
        c0 = cyc;
        while (cyc < c0 + 6) @(negedge clk);
        s_if.draw = 1'b0;
        wait_drain("abort_drain", SN + 10);
        repeat (10) @(negedge clk);
        check("abort_final_idle", 64'(s_state), 64'd0);

        // Default-size frame.
        @(negedge clk);
        b_if.draw = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        n = 0;
        while (b_done_cnt == 0 && n < BN + 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("big_rearm_state", 64'(b_state), 64'd4);
        b_if.draw = 1'b0;
        repeat (3) @(negedge clk);
        check("big_plot_count", 64'(b_plots), 64'(BN));
        check("big_first_plot_cycle", 64'(b_first_cyc), 64'(c0 + 1));
        check("big_plot_gaps", 64'(b_gaps), 64'h0);
        check("big_last_x", 64'(b_last_x), 64'd159);
        check("big_last_y", 64'(b_last_y), 64'd119);
        check("big_colour_errs", 64'(b_bad_col), 64'h0);
        check("big_done_count", 64'(b_done_cnt), 64'd1);
        check("big_done_cycle", 64'(b_done_cyc), 64'(c0 + 19202 - 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
